// File: rtl/expr_stack.sv
// Operand stack for the stack-processor datapath: one push/pop/poppush/swap/dup per clock,
// with sticky overflow/underflow flags and a same-cycle reject pulse.
module expr_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int DUP_W = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             es_act_i,
    input  logic [2:0]       es_op_i,
    input  logic             pop_amt_i,
    input  logic [DUP_W-1:0] dup_num_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             err_clr_i,
    output logic [WIDTH-1:0] top_o,
    output logic [WIDTH-1:0] next_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             ovf_o,
    output logic             unf_o,
    output logic             op_err_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = ((CNT_W > DUP_W) ? CNT_W : DUP_W) + 1;

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_PUSH    = 3'b001;
    localparam logic [2:0] OP_POP     = 3'b010;
    localparam logic [2:0] OP_POPPUSH = 3'b011;
    localparam logic [2:0] OP_SWAP    = 3'b100;
    localparam logic [2:0] OP_DUP     = 3'b101;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [CNT_W-1:0] pop_n;
    logic [CNT_W-1:0] pp_count;
    logic [AW-1:0]    top_idx, nxt_idx, src_idx;
    logic [IW-1:0]    cnt_ext, dup_ext;
    logic             full_c;
    logic             set_ovf, set_unf, reserved_op;
    logic             wr_a_en, wr_b_en;
    logic [AW-1:0]    wr_a_addr, wr_b_addr;
    logic [WIDTH-1:0] wr_a_data, wr_b_data;

    // Distances below top are widened so count-1-dupNum cannot wrap before the bound check.
    assign cnt_ext  = IW'(count_q);
    assign dup_ext  = IW'(dup_num_i);
    assign pop_n    = pop_amt_i ? CNT_W'(2) : CNT_W'(1);
    assign pp_count = count_q - pop_n;
    assign top_idx  = AW'(count_q - CNT_W'(1));
    assign nxt_idx  = AW'(count_q - CNT_W'(2));
    assign src_idx  = AW'(cnt_ext - IW'(1) - dup_ext);
    assign full_c   = (count_q == CNT_W'(DEPTH));

    always_comb begin
        count_d     = count_q;
        set_ovf     = 1'b0;
        set_unf     = 1'b0;
        reserved_op = 1'b0;
        wr_a_en     = 1'b0;
        wr_a_addr   = '0;
        wr_a_data   = '0;
        wr_b_en     = 1'b0;
        wr_b_addr   = '0;
        wr_b_data   = '0;
        if (es_act_i) begin
            case (es_op_i)
                OP_NOP: ;
                OP_PUSH: begin
                    if (full_c) begin
                        set_ovf = 1'b1;
                    end else begin
                        wr_a_en   = 1'b1;
                        wr_a_addr = AW'(count_q);
                        wr_a_data = din_i;
                        count_d   = count_q + CNT_W'(1);
                    end
                end
                OP_POP: begin
                    if (count_q < pop_n) set_unf = 1'b1;
                    else                 count_d = pp_count;
                end
                OP_POPPUSH: begin
                    if (count_q < pop_n) begin
                        set_unf = 1'b1;
                    end else begin
                        wr_a_en   = 1'b1;
                        wr_a_addr = AW'(pp_count);
                        wr_a_data = din_i;
                        count_d   = pp_count + CNT_W'(1);
                    end
                end
                OP_SWAP: begin
                    if (count_q < CNT_W'(2)) begin
                        set_unf = 1'b1;
                    end else begin
                        wr_a_en   = 1'b1;
                        wr_a_addr = top_idx;
                        wr_a_data = mem_q[nxt_idx];
                        wr_b_en   = 1'b1;
                        wr_b_addr = nxt_idx;
                        wr_b_data = mem_q[top_idx];
                    end
                end
                OP_DUP: begin
                    // A missing source entry is reported ahead of a full stack.
                    if (dup_ext >= cnt_ext) begin
                        set_unf = 1'b1;
                    end else if (full_c) begin
                        set_ovf = 1'b1;
                    end else begin
                        wr_a_en   = 1'b1;
                        wr_a_addr = AW'(count_q);
                        wr_a_data = mem_q[src_idx];
                        count_d   = count_q + CNT_W'(1);
                    end
                end
                default: reserved_op = 1'b1;
            endcase
        end
    end

    // A fresh error wins over errClr; errClr still drops the other flag.
    always_comb begin
        ovf_d = set_ovf ? 1'b1 : (err_clr_i ? 1'b0 : ovf_q);
        unf_d = set_unf ? 1'b1 : (err_clr_i ? 1'b0 : unf_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is not reset; entries at or above count are never visible.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_a_en && wr_a_addr == AW'(i))
                    mem_q[i] <= wr_a_data;
                else if (wr_b_en && wr_b_addr == AW'(i))
                    mem_q[i] <= wr_b_data;
            end
        end
    end

    assign top_o    = (count_q != '0) ? mem_q[top_idx] : '0;
    assign next_o   = (count_q >= CNT_W'(2)) ? mem_q[nxt_idx] : '0;
    assign count_o  = count_q;
    assign empty_o  = (count_q == '0);
    assign full_o   = full_c;
    assign ovf_o    = ovf_q;
    assign unf_o    = unf_q;
    assign op_err_o = set_ovf | set_unf | reserved_op;

endmodule

// File: tb/tb_expr_stack.sv
// Scoreboard bench for expr_stack: stimulus queues expected opErr and post-edge state,
// a negedge monitor pops and compares.
module tb_expr_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int DUP_W = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, POPPUSH = 3'd3,
                           SWAP = 3'd4, DUP = 3'd5, RSV = 3'd6;

    logic             clk = 1'b0;
    logic             rst;
    logic             es_act;
    logic [2:0]       es_op;
    logic             pop_amt;
    logic [DUP_W-1:0] dup_num;
    logic [WIDTH-1:0] din;
    logic             err_clr;
    logic [WIDTH-1:0] top_w, next_w;
    logic [CNT_W-1:0] count_w;
    logic             empty_w, full_w, ovf_w, unf_w, op_err_w;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic        err;
        logic [15:0] top;
        logic [15:0] nxt;
        int          cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   state_pending = 0;

    expr_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DUP_W(DUP_W)) dut (
        .clk_i(clk), .rst_i(rst), .es_act_i(es_act), .es_op_i(es_op),
        .pop_amt_i(pop_amt), .dup_num_i(dup_num), .din_i(din), .err_clr_i(err_clr),
        .top_o(top_w), .next_o(next_w), .count_o(count_w), .empty_o(empty_w),
        .full_o(full_w), .ovf_o(ovf_w), .unf_o(unf_w), .op_err_o(op_err_w)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string what, input logic [31:0] got,
                       input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s.%s: got %h expected %h", nm, what, got, want);
        end
    endtask

    task automatic op(input string nm, input logic act, input logic [2:0] opc,
                      input logic pa, input logic [1:0] dn, input logic [15:0] d,
                      input logic clr, input logic e, input logic [15:0] t,
                      input logic [15:0] nx, input int c, input logic ov, input logic un);
        exp_t r;
        @(posedge clk);
        #1;
        es_act  = act;
        es_op   = opc;
        pop_amt = pa;
        dup_num = dn;
        din     = d;
        err_clr = clr;
        r.name = nm; r.err = e; r.top = t; r.nxt = nx; r.cnt = c; r.ovf = ov; r.unf = un;
        exp_q.push_back(r);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            es_act  = 1'b0;
            es_op   = NOP;
            err_clr = 1'b0;
        end
    endtask

    // opErr is checked before the edge; the resulting state one negedge later.
    always @(negedge clk) begin
        if (state_pending) begin
            chk(cur.name, "top",   32'(top_w),   32'(cur.top));
            chk(cur.name, "next",  32'(next_w),  32'(cur.nxt));
            chk(cur.name, "count", 32'(count_w), 32'(cur.cnt));
            chk(cur.name, "empty", 32'(empty_w), 32'(cur.cnt == 0));
            chk(cur.name, "full",  32'(full_w),  32'(cur.cnt == DEPTH));
            chk(cur.name, "ovf",   32'(ovf_w),   32'(cur.ovf));
            chk(cur.name, "unf",   32'(unf_w),   32'(cur.unf));
            $display("[TB] %-10s top=%h next=%h count=%0d ovf=%b unf=%b", cur.name,
                     top_w, next_w, count_w, ovf_w, unf_w);
            state_pending = 0;
        end
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk(cur.name, "opErr", 32'(op_err_w), 32'(cur.err));
            state_pending = 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; es_act = 1'b0; es_op = NOP; pop_amt = 1'b0; dup_num = '0;
        din = '0; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        //  name          act  op       pa  dn  din      clr  err  top      next     cnt ovf unf
        op("reset",      1,   NOP,     0,  0,  16'h0,   0,   0,   16'h0,   16'h0,   0,  0,  0);
        op("push11",     1,   PUSH,    0,  0,  16'h11,  0,   0,   16'h11,  16'h0,   1,  0,  0);
        op("push22",     1,   PUSH,    0,  0,  16'h22,  0,   0,   16'h22,  16'h11,  2,  0,  0);
        op("push33",     1,   PUSH,    0,  0,  16'h33,  0,   0,   16'h33,  16'h22,  3,  0,  0);
        op("swap",       1,   SWAP,    0,  0,  16'h0,   0,   0,   16'h22,  16'h33,  3,  0,  0);
        op("poppush2",   1,   POPPUSH, 1,  0,  16'h55,  0,   0,   16'h55,  16'h11,  2,  0,  0);
        op("dup1",       1,   DUP,     0,  1,  16'h0,   0,   0,   16'h11,  16'h55,  3,  0,  0);
        op("dup3_unf",   1,   DUP,     0,  3,  16'h0,   0,   1,   16'h11,  16'h55,  3,  0,  1);
        op("clr_unf",    1,   NOP,     0,  0,  16'h0,   1,   0,   16'h11,  16'h55,  3,  0,  0);
        op("pop2",       1,   POP,     1,  0,  16'h0,   0,   0,   16'h11,  16'h0,   1,  0,  0);
        op("pop1",       1,   POP,     0,  0,  16'h0,   0,   0,   16'h0,   16'h0,   0,  0,  0);
        op("pop_empty",  1,   POP,     0,  0,  16'h0,   0,   1,   16'h0,   16'h0,   0,  0,  1);
        op("swap_clr",   1,   SWAP,    0,  0,  16'h0,   1,   1,   16'h0,   16'h0,   0,  0,  1);
        op("clr_unf2",   1,   NOP,     0,  0,  16'h0,   1,   0,   16'h0,   16'h0,   0,  0,  0);
        op("reserved",   1,   RSV,     0,  0,  16'h0,   0,   1,   16'h0,   16'h0,   0,  0,  0);
        for (int i = 0; i < DEPTH; i++) begin
            op("fill", 1, PUSH, 0, 0, 16'h100 + 16'(i), 0, 0, 16'h100 + 16'(i),
               (i == 0) ? 16'h0 : 16'h100 + 16'(i) - 16'h1, i + 1, 0, 0);
        end
        op("push_ovf",   1,   PUSH,    0,  0,  16'hDEAD,0,   1,   16'h10F, 16'h10E, 16, 1,  0);
        op("dup_ovf",    1,   DUP,     0,  0,  16'h0,   0,   1,   16'h10F, 16'h10E, 16, 1,  0);
        op("clr_ovf",    1,   NOP,     0,  0,  16'h0,   1,   0,   16'h10F, 16'h10E, 16, 0,  0);
        op("push_ovf2",  1,   PUSH,    0,  0,  16'hBEEF,0,   1,   16'h10F, 16'h10E, 16, 1,  0);
        op("pp_full",    1,   POPPUSH, 0,  0,  16'h77,  0,   0,   16'h77,  16'h10E, 16, 1,  0);
        op("act_off",    0,   PUSH,    0,  0,  16'h99,  0,   0,   16'h77,  16'h10E, 16, 1,  0);
        op("pop_a",      1,   POP,     1,  0,  16'h0,   0,   0,   16'h10D, 16'h10C, 14, 1,  0);
        op("pop_b",      1,   POP,     1,  0,  16'h0,   0,   0,   16'h10B, 16'h10A, 12, 1,  0);
        op("pop_c",      1,   POP,     1,  0,  16'h0,   0,   0,   16'h109, 16'h108, 10, 1,  0);
        op("pop_d",      1,   POP,     1,  0,  16'h0,   0,   0,   16'h107, 16'h106, 8,  1,  0);
        op("pop_e",      1,   POP,     1,  0,  16'h0,   0,   0,   16'h105, 16'h104, 6,  1,  0);
        op("pop_f",      1,   POP,     0,  0,  16'h0,   0,   0,   16'h104, 16'h103, 5,  1,  0);
        idle(3);

        // Asynchronous reset between edges with a PUSH presented.
        @(posedge clk);
        #1;
        es_act = 1'b1; es_op = PUSH; din = 16'hAA;
        #2 rst = 1'b1;
        #1;
        chk("async_rst", "count", 32'(count_w), 32'd0);
        chk("async_rst", "ovf",   32'(ovf_w),   32'd0);
        chk("async_rst", "unf",   32'(unf_w),   32'd0);
        chk("async_rst", "top",   32'(top_w),   32'd0);
        chk("async_rst", "empty", 32'(empty_w), 32'd1);
        $display("[TB] async_rst  count=%0d ovf=%b unf=%b empty=%b", count_w, ovf_w, unf_w, empty_w);
        @(posedge clk);
        #1 rst = 1'b0; es_act = 1'b0;

        op("post_rst",   1,   NOP,     0,  0,  16'h0,   0,   0,   16'h0,   16'h0,   0,  0,  0);
        op("push44",     1,   PUSH,    0,  0,  16'h44,  0,   0,   16'h44,  16'h0,   1,  0,  0);
        op("pop2_unf",   1,   POP,     1,  0,  16'h0,   0,   1,   16'h44,  16'h0,   1,  0,  1);
        idle(4);

        if (exp_q.size() != 0 || state_pending) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
